// File: rtl/pulse_train_generator_if.sv
// Duration handshake bundle for the pulse train generator.
// Master supplies a low-phase length and start mode; slave signals readiness.
interface pulse_train_generator_if;
    logic [11:0] dur_in;
    logic        dur_valid;
    logic        dur_ready;
    logic        mode;

    modport master (
        output dur_in,
        output dur_valid,
        output mode,
        input  dur_ready
    );

    modport slave (
        input  dur_in,
        input  dur_valid,
        input  mode,
        output dur_ready
    );
endinterface

// File: rtl/pulse_train_generator.sv
// Pulse train generator: one high cycle followed by D low cycles per period,
// single-shot or continuous, with a one-deep shadow for the next period length.
module pulse_train_generator #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pulse_train_generator_if.slave dur,
    input  logic                 stop,
    output logic                 pulse_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pulse_cnt,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t             state_q, state_d;
    logic [11:0]        active_q, active_d;
    logic [11:0]        shadow_q, shadow_d;
    logic [11:0]        low_q, low_d;
    logic               shadow_vld_q, shadow_vld_d;
    logic               mode_q, mode_d;
    logic               rdy_en_q;
    logic               pulse_d, done_d, err_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               xfer, xfer_zero, xfer_ok, low_last;

    // Readiness waits for the first clock edge after reset release.
    assign dur.dur_ready = rdy_en_q & ((state_q == IDLE) | ~shadow_vld_q);
    assign xfer          = dur.dur_valid & dur.dur_ready;
    assign xfer_zero     = xfer & (dur.dur_in == 12'd0);
    assign xfer_ok       = xfer & ~xfer_zero;
    assign low_last      = (low_q == 12'd1);
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        low_d        = low_q;
        mode_d       = mode_q;
        cnt_d        = pulse_cnt;
        done_d       = 1'b0;
        err_d        = err | xfer_zero;

        if (busy && xfer_ok) begin
            shadow_d     = dur.dur_in;
            shadow_vld_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (xfer_ok) begin
                    state_d      = HIGH;
                    active_d     = dur.dur_in;
                    mode_d       = dur.mode;
                    cnt_d        = CNT_W'(1);
                    shadow_vld_d = 1'b0;
                end
            end
            HIGH: begin
                state_d = LOW;
                low_d   = active_q;
            end
            LOW: begin
                if (!low_last) begin
                    low_d = low_q - 12'd1;
                end else if (mode_q) begin
                    state_d = HIGH;
                    cnt_d   = pulse_cnt + CNT_W'(1);
                    if (shadow_vld_q) begin
                        active_d     = shadow_q;
                        shadow_vld_d = 1'b0;
                    end
                end else begin
                    state_d      = IDLE;
                    done_d       = 1'b1;
                    shadow_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything except the sticky error.
        if (busy && stop) begin
            state_d      = IDLE;
            shadow_vld_d = 1'b0;
            done_d       = 1'b0;
            cnt_d        = pulse_cnt;
            low_d        = low_q;
            active_d     = active_q;
        end

        pulse_d = (state_d == HIGH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            active_q     <= '0;
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            low_q        <= '0;
            mode_q       <= 1'b0;
            rdy_en_q     <= 1'b0;
            pulse_out    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            pulse_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            low_q        <= low_d;
            mode_q       <= mode_d;
            rdy_en_q     <= 1'b1;
            pulse_out    <= pulse_d;
            done         <= done_d;
            err          <= err_d;
            pulse_cnt    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator: period-position reference
// model checked every cycle, plus directed literal expectations.
module tb_pulse_train_generator;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             stop = 1'b0;
    logic             pulse_out, busy, done, err;
    logic [CNT_W-1:0] pulse_cnt;

    pulse_train_generator_if dif();

    pulse_train_generator #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .dur      (dif),
        .stop     (stop),
        .pulse_out(pulse_out),
        .busy     (busy),
        .done     (done),
        .pulse_cnt(pulse_cnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: position inside the current period, 0 = high cycle.
    bit               m_run, m_single, m_pend, m_done, m_err, m_rdy;
    int               m_d, m_pos, m_pend_d;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ready, m_x, m_z, m_ok;

    assign m_ready = m_rdy && (!m_run || !m_pend);
    assign m_x     = dif.dur_valid && m_ready;
    assign m_z     = m_x && (dif.dur_in == 12'd0);
    assign m_ok    = m_x && !m_z;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run <= 0; m_single <= 0; m_pend <= 0; m_done <= 0;
            m_err <= 0; m_rdy <= 0; m_d <= 0; m_pos <= 0;
            m_pend_d <= 0; m_cnt <= '0;
        end else begin
            m_rdy  <= 1;
            m_done <= 0;
            if (m_z) m_err <= 1;
            if (!m_run) begin
                if (m_ok) begin
                    m_run    <= 1;
                    m_d      <= int'(dif.dur_in);
                    m_single <= !dif.mode;
                    m_pos    <= 0;
                    m_cnt    <= CNT_W'(1);
                    m_pend   <= 0;
                end
            end else if (stop) begin
                m_run  <= 0;
                m_pend <= 0;
            end else if (m_pos == m_d) begin
                if (m_single) begin
                    m_run  <= 0;
                    m_done <= 1;
                    m_pend <= 0;
                end else begin
                    m_pos <= 0;
                    m_cnt <= m_cnt + CNT_W'(1);
                    if (m_pend) begin
                        m_d    <= m_pend_d;
                        m_pend <= 0;
                    end else if (m_ok) begin
                        m_pend   <= 1;
                        m_pend_d <= int'(dif.dur_in);
                    end
                end
            end else begin
                m_pos <= m_pos + 1;
                if (m_ok) begin
                    m_pend   <= 1;
                    m_pend_d <= int'(dif.dur_in);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("pulse_out", pulse_out, m_run && (m_pos == 0));
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("dur_ready", dif.dur_ready, m_ready);
        chk("pulse_cnt", pulse_cnt, m_cnt);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [11:0] d, logic m);
        dif.dur_valid = 1'b1;
        dif.dur_in    = d;
        dif.mode      = m;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bc;
        bit seen;
        int pat31 [6] = '{1, 0, 0, 1, 0, 0};
        int p32 [8] = '{0, 0, 0, 1, 0, 1, 0, 1};
        int r32 [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        int p34 [4] = '{1, 0, 1, 0};

        dif.dur_valid = 1'b0;
        dif.dur_in    = '0;
        dif.mode      = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", dif.dur_ready, 0);
        chk("rst_pulse", pulse_out, 0);
        chk("rst_cnt", pulse_cnt, 0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", dif.dur_ready, 0);
        cyc();
        @(negedge clk);
        chk("ready_after_edge", dif.dur_ready, 1);

        // Single-shot D=3
        cyc(); send(12'd3, 1'b0);
        cyc(); dif.dur_valid = 1'b0;
        @(negedge clk);
        chk("ss_c1_pulse", pulse_out, 1);
        chk("ss_c1_cnt", pulse_cnt, 1);
        for (int c = 2; c <= 4; c++) begin
            cyc(); @(negedge clk);
            chk("ss_low_pulse", pulse_out, 0);
            chk("ss_low_busy", busy, 1);
        end
        cyc(); @(negedge clk);
        chk("ss_c5_done", done, 1);
        chk("ss_c5_busy", busy, 0);
        chk("ss_c5_cnt", pulse_cnt, 1);
        cyc(); @(negedge clk);
        chk("ss_c6_done", done, 0);

        // Continuous D=2, counter wrap after 300 pulses
        cyc(); send(12'd2, 1'b1);
        cyc(); dif.dur_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("cont_seq", pulse_out, pat31[i]);
            cyc();
        end
        n = 2;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pulse_out) n++;
            if (n == 300) begin
                seen = 1;
                break;
            end
            cyc();
        end
        chk("cont_300_reached", seen, 1);
        chk("cont_cnt_wrap", pulse_cnt, 44);
        cyc(); stop = 1'b1;
        cyc(); stop = 1'b0;
        @(negedge clk);
        chk("cont_stop_busy", busy, 0);

        // Continuous D=5 with shadow D=1 mid-LOW
        cyc(); send(12'd5, 1'b1);
        cyc(); dif.dur_valid = 1'b0;
        @(negedge clk);
        chk("sh_c1_pulse", pulse_out, 1);
        cyc();
        cyc(); send(12'd1, 1'b1);
        @(negedge clk);
        chk("sh_c3_ready", dif.dur_ready, 1);
        cyc(); dif.dur_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("sh_pulse", pulse_out, p32[i]);
            chk("sh_ready", dif.dur_ready, r32[i]);
            cyc();
        end
        stop = 1'b1;
        cyc(); stop = 1'b0;

        // D=0 transfer in IDLE
        cyc(); send(12'd0, 1'b0);
        @(negedge clk);
        chk("zero_ready", dif.dur_ready, 1);
        cyc(); dif.dur_valid = 1'b0;
        @(negedge clk);
        chk("zero_busy", busy, 0);
        chk("zero_err", err, 1);

        // Stop during LOW of continuous D=10, then restart with D=1
        cyc(); send(12'd10, 1'b1);
        cyc(); dif.dur_valid = 1'b0;
        cyc();
        cyc(); stop = 1'b1;
        cyc(); stop = 1'b0;
        @(negedge clk);
        chk("stop_pulse", pulse_out, 0);
        chk("stop_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); @(negedge clk);
            chk("stop_no_done", done, 0);
        end
        cyc(); send(12'd1, 1'b1);
        cyc(); dif.dur_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("restart_seq", pulse_out, p34[i]);
            cyc();
        end
        stop = 1'b1;
        cyc(); stop = 1'b0;

        // Maximum D=4095 single-shot
        cyc(); send(12'd4095, 1'b0);
        cyc(); dif.dur_valid = 1'b0;
        bc = 0;
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) bc++;
            cyc();
        end
        chk("max_done_seen", seen, 1);
        chk("max_busy_cycles", bc, 4096);
        cyc();

        // Randomized traffic
        for (int i = 0; i < 15000; i++) begin
            int r;
            r = int'($urandom % 16);
            dif.dur_valid = ($urandom % 4) == 0;
            if (r == 0)
                dif.dur_in = 12'd0;
            else if (r < 12)
                dif.dur_in = 12'($urandom_range(1, 5));
            else
                dif.dur_in = 12'($urandom_range(6, 40));
            dif.mode = 1'($urandom % 2);
            stop = ($urandom % 40) == 0;
            cyc();
        end
        dif.dur_valid = 1'b0;
        stop = 1'b0;
        cyc();
        stop = 1'b1;
        cyc(); stop = 1'b0;

        // Asynchronous reset mid-HIGH
        cyc(); send(12'd3, 1'b1);
        cyc(); dif.dur_valid = 1'b0;
        #1;
        chk("ar_pre_pulse", pulse_out, 1);
        #1 reset = 1'b1;
        #1;
        chk("ar_pulse", pulse_out, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready", dif.dur_ready, 0);
        chk("ar_cnt", pulse_cnt, 0);
        chk("ar_err", err, 0);
        chk("ar_done", done, 0);
        cyc();
        #2 reset = 1'b0;
        cyc();
        cyc(); send(12'd2, 1'b0);
        cyc(); dif.dur_valid = 1'b0;
        @(negedge clk);
        chk("ar_restart_pulse", pulse_out, 1);
        repeat (6) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pulse_train_generator.md
PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

Interface
REQ-001 Parameter CNT_W, default 8, width of the emitted-pulse counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 dur_in  input  12  low-phase length D in clk cycles.
REQ-005 dur_valid  input  1  dur_in valid this cycle.
REQ-006 dur_ready  output  1  block accepts dur_in this cycle; transfer = dur_valid & dur_ready.
REQ-007 mode  input  1  0 = single-shot, 1 = continuous; sampled at transfer from IDLE only.
REQ-008 stop  input  1  abort the running train.
REQ-009 pulse_out  output  1  generated signal, registered.
REQ-010 busy  output  1  high while state is not IDLE.
REQ-011 done  output  1  one-cycle strobe at single-shot completion.
REQ-012 pulse_cnt  output  CNT_W  number of high pulses emitted since the last start.
REQ-013 err  output  1  sticky flag; a D=0 transfer has been received.

Function
REQ-014 States: IDLE, HIGH, LOW; one period = 1 cycle pulse_out=1 (HIGH) followed by D cycles pulse_out=0 (LOW), so a matching duration measurer reads D+1.
REQ-015 IDLE: dur_ready=1; a transfer with D>=1 in cycle t loads D into the active register, latches mode, clears pulse_cnt and enters HIGH, so pulse_out=1 in cycle t+1.
REQ-016 HIGH lasts exactly one cycle; pulse_cnt increments in that cycle, wrapping from 2^CNT_W-1 to 0; next state is LOW with a 12-bit low counter loaded to D.
REQ-017 LOW holds pulse_out=0 for exactly D cycles (cycles t+2 .. t+D+1), decrementing the low counter.
REQ-018 End of LOW, continuous: re-enter HIGH (next high at t+D+2) using the shadow value if one is pending, else the active D.
REQ-019 End of LOW, single-shot: done=1 for one cycle at t+D+2 while state returns to IDLE; pulse_out stays 0.
REQ-020 Running (HIGH or LOW): dur_ready = shadow register empty; an accepted D>=1 is stored in the shadow and applied only at the next period start, never mid-period.
REQ-021 A transfer with D=0, in any state, completes the handshake, is discarded, and sets err; the state is unaffected.
REQ-022 stop=1 while running: next cycle pulse_out=0, state=IDLE, shadow cleared, done not asserted, pulse_cnt held.
REQ-023 stop=1 in IDLE has no effect; a simultaneous transfer in IDLE is accepted and starts the train.
REQ-024 stop=1 while running together with an accepted transfer: the transfer is discarded.
REQ-025 In single-shot mode, shadow transfers are accepted but never used, and they are cleared on return to IDLE.
REQ-026 D=4095 is a legal maximum, giving a period of 4096 cycles; the low counter does not wrap.

Reset
REQ-027 While reset is high, asynchronously: state=IDLE, pulse_out=0, busy=0, done=0, dur_ready=0, pulse_cnt=0, err=0, and the active register, shadow register and low counter are all 0.
REQ-028 First transfer is accepted no earlier than the first rising clk edge after reset deasserts; dur_ready=1 from that cycle.
REQ-029 Reset asserted mid-period forces pulse_out=0 immediately, without waiting for a clock edge, and any pending shadow is lost.

Verification
REQ-030 Single-shot, mode=0, D=3 at cycle 0 -> pulse_out=1 at cycle 1 and 0 at cycles 2-4, done=1 at cycle 5, busy=0 from cycle 5, pulse_cnt=1.
REQ-031 Continuous, D=2 -> pulse_out sequence 1,0,0,1,0,0,1...; after 300 pulses with CNT_W=8, pulse_cnt=44 (wrapped).
REQ-032 Continuous D=5, then shadow D=1 accepted mid-LOW -> current period completes with 5 lows; the following periods are 1,0; dur_ready=0 while the shadow is pending.
REQ-033 D=0 transfer in IDLE -> handshake completes, busy stays 0, err=1 until reset.
REQ-034 stop during LOW of continuous D=10 -> pulse_out=0 and busy=0 the next cycle, done never asserted; a new D=1 start then works normally.
REQ-035 Reset pulse between clk edges mid-HIGH -> pulse_out falls asynchronously and all outputs match REQ-027.
